// File: rtl/h80_io_arbiter_if.sv
// Requester-side and peripheral-side signals of the H80 I/O arbiter.
// master = requesters plus peripheral model; slave = the arbiter itself.
interface h80_io_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  m0_req;
    logic                  m1_req;
    logic                  m0_we;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m0_ack;
    logic                  m1_ack;
    logic                  m0_err;
    logic                  m1_err;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  bus_ce_n;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_rd_n;
    logic                  bus_wr_n;
    logic [DATA_WIDTH-1:0] bus_dout;
    logic                  bus_doe;
    logic [DATA_WIDTH-1:0] bus_din;
    logic                  bus_wait_n;

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
        input  bus_ce_n, bus_addr, bus_rd_n, bus_wr_n, bus_dout, bus_doe,
        output bus_din, bus_wait_n
    );

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
        output bus_ce_n, bus_addr, bus_rd_n, bus_wr_n, bus_dout, bus_doe,
        input  bus_din, bus_wait_n
    );
endinterface

// File: rtl/h80_io_arbiter.sv
// Round-robin arbiter/sequencer sharing one H80 I/O bus between two requesters.
// Access = idle+setup+strobe(>=STROBE_CYCLES, stretched by bus_wait_n, capped by TIMEOUT)+hold; req held until ack.
module h80_io_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int STROBE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic clk,
    input  logic reset,
    h80_io_arbiter_if.slave io
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [1:0]    req_q;
    logic          last_grant;
    logic          gnt;
    logic          we_q;
    logic [CW-1:0] cnt;
    logic          pick;
    logic          done;
    logic          abort;

    // Tie goes to the port that was not served last.
    always_comb begin
        pick = 1'b0;
        case (req_q)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

    // Normal completion has priority over abort when both hold in the same cycle.
    always_comb begin
        done  = (cnt >= CW'(STROBE_CYCLES)) && io.bus_wait_n;
        abort = !done && (cnt >= CW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            req_q       <= 2'b00;
            last_grant  <= 1'b1;
            gnt         <= 1'b0;
            we_q        <= 1'b0;
            cnt         <= '0;
            io.m0_ack   <= 1'b0;
            io.m1_ack   <= 1'b0;
            io.m0_err   <= 1'b0;
            io.m1_err   <= 1'b0;
            io.m0_rdata <= '0;
            io.m1_rdata <= '0;
            io.bus_ce_n <= 1'b1;
            io.bus_addr <= '0;
            io.bus_rd_n <= 1'b1;
            io.bus_wr_n <= 1'b1;
            io.bus_dout <= '0;
            io.bus_doe  <= 1'b0;
        end else begin
            req_q     <= {io.m1_req, io.m0_req};
            io.m0_ack <= 1'b0;
            io.m1_ack <= 1'b0;
            io.m0_err <= 1'b0;
            io.m1_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_q) begin
                        gnt         <= pick;
                        last_grant  <= pick;
                        we_q        <= pick ? io.m1_we : io.m0_we;
                        io.bus_addr <= pick ? io.m1_addr : io.m0_addr;
                        io.bus_dout <= pick ? io.m1_wdata : io.m0_wdata;
                        io.bus_doe  <= pick ? io.m1_we : io.m0_we;
                        io.bus_ce_n <= 1'b0;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    io.bus_rd_n <= we_q;
                    io.bus_wr_n <= ~we_q;
                    cnt         <= CW'(1);
                    state       <= S_STROBE;
                end
                S_STROBE: begin
                    if (done || abort) begin
                        io.bus_rd_n <= 1'b1;
                        io.bus_wr_n <= 1'b1;
                        if (gnt) begin
                            io.m1_ack <= 1'b1;
                            io.m1_err <= abort;
                            if (!we_q) io.m1_rdata <= abort ? '1 : io.bus_din;
                        end else begin
                            io.m0_ack <= 1'b1;
                            io.m0_err <= abort;
                            if (!we_q) io.m0_rdata <= abort ? '1 : io.bus_din;
                        end
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    io.bus_ce_n <= 1'b1;
                    io.bus_doe  <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule
